// File: rtl/qdec_ctx_mem_arb.sv
// ---------------------------------------------------------------------------
// qdec_ctx_mem_arb
//
// Arbitrates the single-port CABAC context memory between three clients:
//   - the context-init sequencer (bulk writes while a slice starts),
//   - the arithmetic decoder writing back updated context states,
//   - the SAO/CQT decode FSMs reading context states.
// One memory access is granted per cycle with fixed priority
// init write > writeback > read. Reads take two cycles to return: the memory
// answers one cycle after mem_re and the answer is then registered here.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   init_we/init_addr/init_wdata/init_done
//                              context-init writes and end-of-init pulse
//   rd_req/rd_addr/rd_rdy      read request handshake
//   rd_data/rd_data_vld        read return ({ctxState[6:0], mps})
//   wb_vld/wb_addr/wb_data/wb_rdy
//                              state writeback handshake
//   mem_addr/mem_wdata/mem_we/mem_re/mem_rdata
//                              context memory port (rdata one cycle after re)
//   busy                       read in flight or init in progress
//   conflict_err               sticky: init write seen while a read was in flight
//
// Optional feature
//   QDEC_CTX_FWD_EN            when defined, a write that hits the address of
//                              the read waiting on mem_rdata replaces that
//                              read's return data with the written value.
// ---------------------------------------------------------------------------
module qdec_ctx_mem_arb (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       init_we,
   input  logic [9:0] init_addr,
   input  logic [7:0] init_wdata,
   input  logic       init_done,
   input  logic       rd_req,
   input  logic [9:0] rd_addr,
   output logic       rd_rdy,
   output logic [7:0] rd_data,
   output logic       rd_data_vld,
   input  logic       wb_vld,
   input  logic [9:0] wb_addr,
   input  logic [7:0] wb_data,
   output logic       wb_rdy,
   output logic [9:0] mem_addr,
   output logic [7:0] mem_wdata,
   output logic       mem_we,
   output logic       mem_re,
   input  logic [7:0] mem_rdata,
   output logic       busy,
   output logic       conflict_err
);

   typedef enum logic [1:0] {IDLE, INIT, RUN} state_e;

   state_e     state_q, state_d;
   logic       s1Vld_q, s2Vld_q;
   logic [7:0] rdData_q, rdData_d;
   logic       conflict_q;
   logic       initGnt, wbGnt, rdGnt, inFlight;
   logic       wrEn;
   logic [9:0] wrAddr;
   logic [7:0] wrData;
`ifdef QDEC_CTX_FWD_EN
   logic [9:0] s1Addr_q;
`endif

   // Fixed-priority arbitration. An init write always wins, even outside the
   // INIT state (it is what moves us into INIT). Writebacks and reads are
   // locked out for the whole INIT state.
   always_comb begin
      inFlight = s1Vld_q | s2Vld_q;
      initGnt  = init_we;
      wbGnt    = wb_vld && (state_q != INIT) && !init_we;
      rdGnt    = rd_req && (state_q != INIT) && !init_we && !wb_vld;
      wrEn     = initGnt | wbGnt;
      wrAddr   = initGnt ? init_addr  : wb_addr;
      wrData   = initGnt ? init_wdata : wb_data;
   end

   // Next-state logic. RUN only falls back to IDLE once nothing is requested
   // and both read pipeline stages have drained.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (init_we)               state_d = INIT;
            else if (rd_req || wb_vld) state_d = RUN;
         end
         INIT: begin
            if (init_done) state_d = IDLE;
         end
         RUN: begin
            if (init_we)                                  state_d = INIT;
            else if (!rd_req && !wb_vld && !inFlight)     state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Combinational handshake and memory-port outputs. They are gated with
   // rst_n so that asserting reset silences the memory port and the ready
   // signals immediately, without waiting for a clock edge.
   always_comb begin
      rd_rdy    = 1'b0;
      wb_rdy    = 1'b0;
      mem_we    = 1'b0;
      mem_re    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (rst_n) begin
         rd_rdy = (state_q != INIT) && !init_we && !wb_vld;
         wb_rdy = (state_q != INIT) && !init_we;
         if (wrEn) begin
            mem_we    = 1'b1;
            mem_addr  = wrAddr;
            mem_wdata = wrData;
         end else if (rdGnt) begin
            mem_re   = 1'b1;
            mem_addr = rd_addr;
         end
      end
   end

   // Return-data selection. By default the read returns what the memory
   // produced; with forwarding, a write landing on the address of the read
   // currently waiting on mem_rdata overrides the (now stale) memory value.
   always_comb begin
      rdData_d = mem_rdata;
`ifdef QDEC_CTX_FWD_EN
      if (wrEn && s1Vld_q && (wrAddr == s1Addr_q)) rdData_d = wrData;
`endif
   end

   // State register, two-stage read pipeline and sticky conflict flag.
   // Stage 1 marks the cycle in which mem_rdata is valid; stage 2 marks the
   // cycle in which the registered data is presented. Reset empties the
   // pipeline so reads in flight are simply forgotten.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         s1Vld_q    <= 1'b0;
         s2Vld_q    <= 1'b0;
         rdData_q   <= '0;
         conflict_q <= 1'b0;
`ifdef QDEC_CTX_FWD_EN
         s1Addr_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         s1Vld_q <= rdGnt;
         s2Vld_q <= s1Vld_q;
         if (s1Vld_q) rdData_q <= rdData_d;
         if (init_we && inFlight) conflict_q <= 1'b1;
`ifdef QDEC_CTX_FWD_EN
         if (rdGnt) s1Addr_q <= rd_addr;
`endif
      end
   end

   assign rd_data      = rdData_q;
   assign rd_data_vld  = s2Vld_q;
   assign busy         = (state_q == INIT) || inFlight;
   assign conflict_err = conflict_q;

endmodule

// File: doc/qdec_ctx_mem_arb.md
QDEC_CTX_MEM_ARB -- requirements
Module: qdec_ctx_mem_arb

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have ports from the context-init sequencer: init_we input 1 (write strobe); init_addr input 10 (address); init_wdata input 8 (data); init_done input 1 (one-cycle end-of-init pulse).
REQ-004 SHALL have read-request ports from the SAO/CQT decode FSMs: rd_req input 1; rd_addr input 10; rd_rdy output 1 (accept).
REQ-005 SHALL have read-return ports: rd_data output 8 ({ctxState[6:0], mps}); rd_data_vld output 1.
REQ-006 SHALL have state-writeback ports from the arithmetic decoder: wb_vld input 1; wb_addr input 10; wb_data input 8; wb_rdy output 1.
REQ-007 SHALL have memory ports: mem_addr output 10; mem_wdata output 8; mem_we output 1; mem_re output 1; mem_rdata input 8 (valid one cycle after mem_re).
REQ-008 SHALL have status ports: busy output 1 (read in flight or INIT state); conflict_err output 1 (sticky).

Function
REQ-009 SHALL implement FSM states IDLE, INIT, RUN; reset state IDLE.
REQ-010 IDLE->INIT on init_we=1; IDLE->RUN on rd_req=1 or wb_vld=1; RUN->IDLE when rd_req=0, wb_vld=0 and no read in flight; INIT->IDLE on init_done=1; RUN->INIT on init_we=1.
REQ-011 SHALL grant one memory access per cycle, fixed priority: init write > writeback > read.
REQ-012 In INIT: rd_rdy=0, wb_rdy=0; each init_we cycle drives mem_we=1, mem_addr=init_addr, mem_wdata=init_wdata combinationally in the same cycle.
REQ-013 Outside INIT: wb_rdy=1; wb_vld=1 drives mem_we=1, mem_addr=wb_addr, mem_wdata=wb_data in the same cycle.
REQ-014 rd_rdy=1 iff state != INIT, init_we=0 and wb_vld=0; a read is accepted when rd_req & rd_rdy, driving mem_re=1, mem_addr=rd_addr.
REQ-015 rd_data SHALL be registered from mem_rdata; rd_data_vld asserts exactly 2 cycles after acceptance; back-to-back accepted reads return back-to-back in order.
REQ-016 SHALL track in-flight reads with a 2-stage valid/address pipeline; busy = state==INIT or any stage valid.
REQ-017 Idle memory outputs SHALL be mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0.
REQ-018 init_we=1 while any read is in flight SHALL set conflict_err=1; in-flight reads still complete normally.
REQ-019 init_we and wb_vld asserted in the same cycle: init write wins; writeback dropped (wb_rdy=0 that cycle).

Reset
REQ-020 rst_n=0 SHALL immediately force state=IDLE, pipeline stages invalid, rd_data_vld=0, rd_data=0, conflict_err=0, mem_we=0, mem_re=0, busy=0.
REQ-021 Reads in flight when reset asserts SHALL be discarded; no rd_data_vld after release for them.
REQ-022 conflict_err SHALL clear only on reset.

Configuration
REQ-023 Macro QDEC_CTX_FWD_EN: when defined, a write (init or writeback) to an address equal to an in-flight read's address SHALL replace that read's return data with the written data (youngest write wins).
REQ-024 Without QDEC_CTX_FWD_EN, no forwarding logic; in-flight reads return the memory value sampled at mem_re.

Verification
REQ-025 Reset then rd_req=1, rd_addr=0x005, mem_rdata=0x3C next cycle -> rd_data_vld=1, rd_data=0x3C exactly 2 cycles after accept.
REQ-026 wb_vld=1 and rd_req=1 same cycle (wb_addr=0x010, wb_data=0x81) -> mem_we=1, mem_addr=0x010, rd_rdy=0; read accepted next cycle.
REQ-027 Read 0x020 accepted at T, writeback 0x020/0x55 at T+1 -> with QDEC_CTX_FWD_EN rd_data=0x55; without it rd_data=old memory value.
REQ-028 init_we=1 with read in flight -> conflict_err=1 until reset; INIT entered; rd_rdy=0 until init_done pulse, then IDLE.
REQ-029 Four consecutive reads 0x001..0x004 -> four consecutive rd_data_vld cycles in order; busy drops 1 cycle after last vld.
REQ-030 rst_n low while read in flight -> all outputs 0 asynchronously; no rd_data_vld after release.
